// File: rtl/operand_load_if.sv
// Handshake and operand bus between a word source and the operand load controller.
interface operand_load_if #(
  parameter int WIDTH = 4096,
  parameter int WORD  = 32
);
  logic             start;
  logic [1:0]       sel;
  logic             abort;
  logic [WORD-1:0]  word_in;
  logic             word_valid;
  logic             word_ready;
  logic [WIDTH-1:0] reg_data;
  logic             en_msg;
  logic             en_exp;
  logic             en_mod;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, sel, abort, word_in, word_valid,
    input  word_ready, reg_data, en_msg, en_exp, en_mod, busy, done, err
  );

  modport slave (
    input  start, sel, abort, word_in, word_valid,
    output word_ready, reg_data, en_msg, en_exp, en_mod, busy, done, err
  );
endinterface

// File: rtl/operand_load_ctrl.sv
// Assembles WIDTH-bit operands from WORD-bit words (LSW first) and pulses the
// load enable of the selected operand register once the last word has arrived.
module operand_load_ctrl #(
  parameter int WIDTH = 4096,
  parameter int WORD  = 32
) (
  input  logic          clk,
  input  logic          rst,
  operand_load_if.slave bus
);
  localparam int NW = WIDTH / WORD;
  localparam int CW = $clog2(NW) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [2:0]       en_q;
  logic             accept;
  logic             last_word;

  assign accept    = ready_q & bus.word_valid;
  assign last_word = (cnt == CW'(NW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 3'b000;
    end else begin
      en_q   <= 3'b000;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          // start outranks abort here; abort has no meaning before a load begins
          if (bus.start) begin
            if (bus.sel != 2'd3) begin
              sel_q   <= bus.sel;
              cnt     <= '0;
              data_q  <= '0;
              state   <= LOAD;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          // abort wins over a word arriving in the same cycle, even the last one
          if (bus.abort) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (accept) begin
            for (int i = 0; i < NW; i++) begin
              if (cnt == CW'(i)) data_q[i*WORD +: WORD] <= bus.word_in;
            end
            cnt <= cnt + CW'(1);
            if (last_word) begin
              state   <= COMMIT;
              ready_q <= 1'b0;
              en_q    <= 3'b001 << sel_q;
            end
          end
        end
        COMMIT: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Enables are masked by rst so a commit cut short by reset never loads a register.
  assign bus.en_msg     = en_q[0] & ~rst;
  assign bus.en_exp     = en_q[1] & ~rst;
  assign bus.en_mod     = en_q[2] & ~rst;
  assign bus.word_ready = ready_q;
  assign bus.reg_data   = data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_operand_load_ctrl.sv
// Randomized scenario bench for operand_load_ctrl with a transaction-level model.
module tb_operand_load_ctrl;
  localparam int WIDTH = 128;
  localparam int WORD  = 32;
  localparam int NW    = WIDTH / WORD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_load_if #(.WIDTH(WIDTH), .WORD(WORD)) bus ();
  operand_load_ctrl #(.WIDTH(WIDTH), .WORD(WORD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.sel = 2'd0; bus.abort = 1'b0; bus.word_in = '0; bus.word_valid = 1'b0;
  endtask

  function automatic logic [2:0] ens();
    return {bus.en_mod, bus.en_exp, bus.en_msg};
  endfunction

  task automatic do_start(input logic [1:0] s);
    bus.start = 1'b1; bus.sel = s;
    tick();
    bus.start = 1'b0; bus.sel = 2'd0;
  endtask

  // Drives one load (already started) to completion and records what it observed.
  // vmode: 0 valid every cycle, 1 valid every other cycle, 2 random valid.
  task automatic feed(input int vmode, input bit fixed, input bit inj,
                      output int nacc, output logic [WIDTH-1:0] model,
                      output logic [2:0] en_or, output int en_cnt, output int en_rel,
                      output int done_cnt, output int done_rel,
                      output logic [WIDTH-1:0] data_at_en,
                      output int ready_bad, output int busy_bad, output int excl_bad);
    int last, en_edge, done_edge;
    logic v;
    logic [2:0] e;
    last = -1; en_edge = -1; done_edge = -1;
    nacc = 0; model = '0; en_or = 3'b000; en_cnt = 0; done_cnt = 0; data_at_en = '0;
    ready_bad = 0; busy_bad = 0; excl_bad = 0;
    for (int t = 0; t < 300; t++) begin
      v = (nacc < NW) && (vmode == 0 || (vmode == 1 && t % 2 == 0) ||
                          (vmode == 2 && $urandom_range(0, 2) != 0));
      bus.word_valid = v;
      bus.word_in    = fixed ? WORD'(32'h11111111 * (nacc + 1)) : $urandom;
      bus.start      = inj && (last < 0 || t <= last + 2) && ($urandom_range(0, 2) == 0);
      bus.sel        = 2'($urandom_range(0, 3));
      if (bus.word_ready !== (nacc < NW)) ready_bad++;
      if (v) begin
        model[nacc*WORD +: WORD] = bus.word_in;
        nacc++;
        if (nacc == NW) last = t;
      end
      tick();
      e = ens();
      if (e !== 3'b000) begin
        en_cnt++;
        en_or |= e;
        if (en_edge < 0) en_edge = t;
        data_at_en = bus.reg_data;
        if (!$onehot(e)) excl_bad++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = t;
      end
      if (bus.err !== 1'b0) excl_bad++;
      if (bus.busy !== (last < 0 || t <= last + 1)) busy_bad++;
      if (last >= 0 && t >= last + 2) break;
    end
    en_rel   = (en_edge < 0 || last < 0) ? -99 : en_edge - last;
    done_rel = (done_edge < 0 || last < 0) ? -99 : done_edge - last;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.sel = 2'd2; bus.word_valid = 1'b1; bus.word_in = $urandom;
    bus.abort = 1'($urandom_range(0, 1));
    tick(); tick();
    checks++; if (bus.word_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.word_ready); end
    checks++; if (ens() !== 3'b000) begin failures++; $display("FAIL rst_en got=%b exp=000", ens()); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    checks++; if (bus.reg_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", bus.reg_data); end
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_mod_load();
    int nacc, en_cnt, en_rel, done_cnt, done_rel, rb, bb, xb;
    logic [2:0] en_or;
    logic [WIDTH-1:0] model, dat;
    logic [WIDTH-1:0] expd;
    expd = 128'h44444444_33333333_22222222_11111111;
    do_start(2'd2);
    checks++; if (bus.busy !== 1'b1 || bus.word_ready !== 1'b1) begin failures++; $display("FAIL s1_after_start got=busy%b/ready%b exp=1/1", bus.busy, bus.word_ready); end
    feed(0, 1'b1, 1'b0, nacc, model, en_or, en_cnt, en_rel, done_cnt, done_rel, dat, rb, bb, xb);
    checks++; if (nacc !== 4) begin failures++; $display("FAIL s1_nacc got=%0d exp=4", nacc); end
    checks++; if (en_or !== 3'b100 || en_cnt !== 1) begin failures++; $display("FAIL s1_enable got=%b x%0d exp=100 x1", en_or, en_cnt); end
    checks++; if (en_rel !== 0) begin failures++; $display("FAIL s1_en_latency got=%0d exp=0", en_rel); end
    checks++; if (dat !== expd) begin failures++; $display("FAIL s1_data got=%h exp=%h", dat, expd); end
    checks++; if (done_cnt !== 1 || done_rel !== 1) begin failures++; $display("FAIL s1_done got=n%0d rel%0d exp=n1 rel1", done_cnt, done_rel); end
    checks++; if (rb !== 0 || bb !== 0 || xb !== 0) begin failures++; $display("FAIL s1_ctrl got=rdy%0d busy%0d excl%0d exp=0", rb, bb, xb); end
    checks++; if (bus.reg_data !== expd) begin failures++; $display("FAIL s1_retain got=%h exp=%h", bus.reg_data, expd); end
  endtask

  task automatic test_toggle_valid();
    int nacc, en_cnt, en_rel, done_cnt, done_rel, rb, bb, xb;
    logic [2:0] en_or;
    logic [WIDTH-1:0] model, dat;
    do_start(2'd0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL s2_busy_start got=%b exp=1", bus.busy); end
    feed(1, 1'b0, 1'b0, nacc, model, en_or, en_cnt, en_rel, done_cnt, done_rel, dat, rb, bb, xb);
    checks++; if (nacc !== 4) begin failures++; $display("FAIL s2_nacc got=%0d exp=4", nacc); end
    checks++; if (en_or !== 3'b001 || en_cnt !== 1 || en_rel !== 0) begin failures++; $display("FAIL s2_enable got=%b x%0d rel%0d exp=001 x1 rel0", en_or, en_cnt, en_rel); end
    checks++; if (dat !== model) begin failures++; $display("FAIL s2_data got=%h exp=%h", dat, model); end
    checks++; if (done_cnt !== 1 || done_rel !== 1) begin failures++; $display("FAIL s2_done got=n%0d rel%0d exp=n1 rel1", done_cnt, done_rel); end
    checks++; if (rb !== 0 || bb !== 0 || xb !== 0) begin failures++; $display("FAIL s2_ctrl got=rdy%0d busy%0d excl%0d exp=0", rb, bb, xb); end
  endtask

  task automatic test_illegal_sel();
    int nacc, en_cnt, en_rel, done_cnt, done_rel, rb, bb, xb;
    logic [2:0] en_or;
    logic [WIDTH-1:0] model, dat;
    bus.start = 1'b1; bus.sel = 2'd3;
    tick();
    idle_inputs();
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL s3_err got=%b exp=1", bus.err); end
    checks++; if (bus.busy !== 1'b0 || bus.word_ready !== 1'b0 || ens() !== 3'b000) begin failures++; $display("FAIL s3_quiet got=busy%b rdy%b en%b exp=0/0/000", bus.busy, bus.word_ready, ens()); end
    tick();
    checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL s3_err_pulse got=err%b busy%b exp=0/0", bus.err, bus.busy); end
    do_start(2'd1);
    feed(2, 1'b0, 1'b0, nacc, model, en_or, en_cnt, en_rel, done_cnt, done_rel, dat, rb, bb, xb);
    checks++; if (en_or !== 3'b010 || en_cnt !== 1 || dat !== model) begin failures++; $display("FAIL s3_reload got=en%b x%0d data%h exp=010 x1 data%h", en_or, en_cnt, dat, model); end
    checks++; if (done_cnt !== 1 || done_rel !== 1) begin failures++; $display("FAIL s3_done got=n%0d rel%0d exp=n1 rel1", done_cnt, done_rel); end
  endtask

  task automatic test_abort();
    int nacc, en_cnt, en_rel, done_cnt, done_rel, rb, bb, xb, seen;
    logic [2:0] en_or;
    logic [WIDTH-1:0] model, dat, part;
    part = '0;
    do_start(2'd1);
    checks++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL s4_ready got=%b exp=1", bus.word_ready); end
    for (int i = 0; i < 2; i++) begin
      bus.word_valid = 1'b1; bus.word_in = $urandom;
      part[i*WORD +: WORD] = bus.word_in;
      tick();
    end
    bus.abort = 1'b1; bus.word_valid = 1'($urandom_range(0, 1)); bus.word_in = $urandom;
    tick();
    idle_inputs();
    checks++; if (bus.busy !== 1'b0 || bus.word_ready !== 1'b0) begin failures++; $display("FAIL s4_idle got=busy%b rdy%b exp=0/0", bus.busy, bus.word_ready); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (ens() !== 3'b000 || bus.done !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL s4_no_commit got=%0d exp=0", seen); end
    checks++; if (bus.reg_data !== part) begin failures++; $display("FAIL s4_retain got=%h exp=%h", bus.reg_data, part); end
    bus.start = 1'b1; bus.sel = 2'd1; bus.abort = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.busy !== 1'b1 || bus.reg_data !== '0) begin failures++; $display("FAIL s4_restart got=busy%b data%h exp=1/0", bus.busy, bus.reg_data); end
    feed(2, 1'b0, 1'b0, nacc, model, en_or, en_cnt, en_rel, done_cnt, done_rel, dat, rb, bb, xb);
    checks++; if (en_or !== 3'b010 || en_cnt !== 1 || dat !== model) begin failures++; $display("FAIL s4_reload got=en%b x%0d data%h exp=010 x1 data%h", en_or, en_cnt, dat, model); end
    checks++; if (done_rel !== 1 || rb !== 0 || bb !== 0) begin failures++; $display("FAIL s4_reload_ctrl got=rel%0d rdy%0d busy%0d exp=1/0/0", done_rel, rb, bb); end
  endtask

  task automatic test_abort_last();
    int seen;
    logic [WIDTH-1:0] part;
    part = '0;
    do_start(2'd2);
    for (int i = 0; i < 3; i++) begin
      bus.word_valid = 1'b1; bus.word_in = $urandom;
      part[i*WORD +: WORD] = bus.word_in;
      tick();
    end
    bus.word_valid = 1'b1; bus.word_in = $urandom; bus.abort = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.busy !== 1'b0 || bus.word_ready !== 1'b0) begin failures++; $display("FAIL s5_idle got=busy%b rdy%b exp=0/0", bus.busy, bus.word_ready); end
    checks++; if (bus.reg_data !== part) begin failures++; $display("FAIL s5_discard got=%h exp=%h", bus.reg_data, part); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (ens() !== 3'b000 || bus.done !== 1'b0) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL s5_no_commit got=%0d exp=0", seen); end
  endtask

  task automatic test_reset_commit();
    int seen;
    do_start(2'd0);
    for (int i = 0; i < NW; i++) begin
      bus.word_valid = 1'b1; bus.word_in = $urandom;
      tick();
    end
    idle_inputs();
    checks++; if (ens() !== 3'b001) begin failures++; $display("FAIL s6_commit_en got=%b exp=001", ens()); end
    rst = 1'b1;
    #1;
    checks++; if (ens() !== 3'b000) begin failures++; $display("FAIL s6_en_masked got=%b exp=000", ens()); end
    tick();
    checks++; if (ens() !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.word_ready !== 1'b0) begin
      failures++; $display("FAIL s6_outputs got=en%b busy%b done%b err%b rdy%b exp=0", ens(), bus.busy, bus.done, bus.err, bus.word_ready); end
    checks++; if (bus.reg_data !== '0) begin failures++; $display("FAIL s6_data got=%h exp=0", bus.reg_data); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ens() !== 3'b000 || bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL s6_after_rst got=%0d exp=0", seen); end
  endtask

  task automatic test_start_ignored();
    int nacc, en_cnt, en_rel, done_cnt, done_rel, rb, bb, xb;
    logic [2:0] en_or;
    logic [WIDTH-1:0] model, dat;
    do_start(2'd2);
    feed(2, 1'b0, 1'b1, nacc, model, en_or, en_cnt, en_rel, done_cnt, done_rel, dat, rb, bb, xb);
    checks++; if (en_or !== 3'b100 || en_cnt !== 1 || dat !== model) begin failures++; $display("FAIL s6_start_ign got=en%b x%0d data%h exp=100 x1 data%h", en_or, en_cnt, dat, model); end
    checks++; if (done_cnt !== 1 || done_rel !== 1 || rb !== 0 || bb !== 0 || xb !== 0) begin
      failures++; $display("FAIL s6_start_ign_ctrl got=n%0d rel%0d rdy%0d busy%0d excl%0d exp=1/1/0/0/0", done_cnt, done_rel, rb, bb, xb); end
  endtask

  task automatic test_back_to_back();
    int nacc, en_cnt, en_rel, done_cnt, done_rel, rb, bb, xb;
    logic [2:0] en_or, want;
    logic [WIDTH-1:0] model, dat;
    logic [1:0] s;
    for (int n = 0; n < 6; n++) begin
      s = 2'($urandom_range(0, 2));
      want = 3'b001 << s;
      do_start(s);
      feed(2, 1'b0, 1'($urandom_range(0, 1)), nacc, model, en_or, en_cnt, en_rel, done_cnt, done_rel, dat, rb, bb, xb);
      checks++; if (en_or !== want || en_cnt !== 1 || en_rel !== 0) begin failures++; $display("FAIL b2b%0d_enable got=%b x%0d rel%0d exp=%b x1 rel0", n, en_or, en_cnt, en_rel, want); end
      checks++; if (dat !== model) begin failures++; $display("FAIL b2b%0d_data got=%h exp=%h", n, dat, model); end
      checks++; if (done_cnt !== 1 || done_rel !== 1 || rb + bb + xb !== 0) begin
        failures++; $display("FAIL b2b%0d_ctrl got=n%0d rel%0d bad%0d exp=1/1/0", n, done_cnt, done_rel, rb + bb + xb); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mod_load();
    test_toggle_valid();
    test_illegal_sel();
    test_abort();
    test_abort_last();
    test_reset_commit();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/operand_load_ctrl.md
OPERAND_LOAD_CTRL -- requirements
Module: operand_load_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4096, bit width of the assembled operand and of each target operand register.
REQ-002 Parameter: WORD, default 32, bit width of one input word; WIDTH SHALL be an integer multiple of WORD, and NW = WIDTH/WORD.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin loading an operand.
REQ-006 sel  input  2  target select, sampled with start: 0=message, 1=exponent, 2=modulus, 3=illegal.
REQ-007 abort  input  1  cancels a load in progress.
REQ-008 word_in  input  WORD  operand word, least-significant word first.
REQ-009 word_valid  input  1  word_in is valid.
REQ-010 word_ready  output  1  controller accepts word_in this cycle.
REQ-011 reg_data  output  WIDTH  assembled operand, driven to the inp port of all three operand registers.
REQ-012 en_msg / en_exp / en_mod  output  1 each  load enables of the message, exponent and modulus registers.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a load has committed.
REQ-015 err  output  1  one-cycle pulse on an illegal start.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, COMMIT and DONE.
REQ-017 IDLE with start=1 and sel!=3: the block SHALL latch sel, clear the word counter and reg_data to 0, and go to LOAD.
REQ-018 IDLE with start=1 and sel=3: err SHALL be 1 in the next cycle for exactly one cycle; the state SHALL stay IDLE.
REQ-019 In IDLE, start together with abort: start SHALL win and abort SHALL be ignored.
REQ-020 In any state other than IDLE, start SHALL be ignored.
REQ-021 LOAD: word_ready SHALL be 1; word_ready SHALL be 0 in every other state.
REQ-022 A word is accepted when word_valid and word_ready are both 1 in the same cycle.
REQ-023 On acceptance, word_in SHALL be written to reg_data[cnt*WORD +: WORD] and cnt SHALL increment.
REQ-024 cnt SHALL be $clog2(NW)+1 bits wide and SHALL never wrap.
REQ-025 When the NW-th word is accepted, the next state SHALL be COMMIT; the accepting cycle and the first cycle in COMMIT are consecutive.
REQ-026 COMMIT: exactly one enable, chosen by the latched sel, SHALL be 1 for exactly one cycle.
REQ-027 reg_data SHALL hold its final value throughout COMMIT; the next state SHALL be DONE.
REQ-028 DONE: done SHALL be 1 for one cycle, then the state SHALL return to IDLE.
REQ-029 Latency SHALL be: last word accepted at edge N, enable high in cycle N+1, done high in cycle N+2.
REQ-030 In LOAD, abort=1 SHALL return the FSM to IDLE next cycle, and no enable and no done SHALL be issued.
REQ-031 If abort and the final word occur in the same cycle, abort SHALL win; the word is discarded and no commit occurs.
REQ-032 abort SHALL be ignored in COMMIT and DONE.
REQ-033 reg_data SHALL retain its contents in IDLE until the next legal start.
REQ-034 The three enables SHALL be mutually exclusive in every cycle.

Reset
REQ-035 rst=1 at a rising edge SHALL force: state=IDLE, cnt=0, reg_data=0, latched sel=0.
REQ-036 The same reset SHALL force word_ready, en_msg, en_exp, en_mod, busy, done and err to 0.
REQ-037 rst SHALL take priority over every other input, including mid-LOAD and in COMMIT; an enable pending in COMMIT SHALL be suppressed.
REQ-038 There SHALL be no asynchronous reset path.

Verification (bench parameters: WIDTH=128, WORD=32, NW=4)
REQ-039 Scenario 1: start, sel=2, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back -> en_mod=1 for one cycle with reg_data=0x44444444_33333333_22222222_11111111, done one cycle later, en_msg=en_exp=0 throughout.
REQ-040 Scenario 2: start, sel=0, word_valid toggled 1/0 each cycle -> exactly 4 words accepted, en_msg asserted 1 cycle after the 4th accept, busy high from the cycle after start until the end of DONE.
REQ-041 Scenario 3: start, sel=3 -> err=1 for one cycle, busy stays 0, all enables 0; a following start with sel=1 loads normally and asserts en_exp.
REQ-042 Scenario 4: start, sel=1, 2 words accepted, abort=1 -> IDLE next cycle, no enable, no done; a new load with sel=1 starts from cnt=0 and reg_data=0.
REQ-043 Scenario 5: abort together with the 4th valid word -> no enable, no done, FSM back in IDLE.
REQ-044 Scenario 6: rst=1 in the COMMIT cycle -> all enables 0 that cycle, all outputs 0 after the edge; start issued during LOAD or DONE has no effect on the load in progress.
